// File: rtl/key_enc.sv
// Debounced 10-key decimal encoder with a valid/ready output register.
// One code per press/release cycle; simultaneous keys are reported as 4'hF with err set.
`timescale 1ns/1ps

module key_enc #(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] in,
  output logic [3:0] out,
  output logic       err,
  output logic       valid,
  input  logic       ready,
  output logic       ovf
);

  // state | meaning
  // IDLE  | no key seen, waiting for a nonzero sample
  // DEB   | press seen, counting identical samples before accepting it
  // HELD  | code emitted, key still down; further key changes ignored
  // REL   | all keys up, counting zero samples before re-arming
  typedef enum logic [1:0] {IDLE, DEB, HELD, REL} state_t;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

  logic [9:0] sync1, s;
  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [9:0] snap, snap_nxt;
  logic       emit;
  logic [3:0] code;
  logic       code_err;
  logic [3:0] n_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= in;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      snap  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      snap  <= snap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    snap_nxt  = snap;
    case (state)
      IDLE: begin
        if (s != '0) begin
          snap_nxt  = s;
          cnt_nxt   = '0;
          state_nxt = DEB;
        end
      end
      DEB: begin
        if (s != snap)
          state_nxt = IDLE;
        else if (cnt == CNT_LAST)
          state_nxt = HELD;
        else
          cnt_nxt = cnt + 8'd1;
      end
      HELD: begin
        if (s == '0) begin
          cnt_nxt   = '0;
          state_nxt = REL;
        end
      end
      REL: begin
        if (s != '0)
          state_nxt = HELD;
        else if (cnt == CNT_LAST)
          state_nxt = IDLE;
        else
          cnt_nxt = cnt + 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    emit = (state == DEB) && (s == snap) && (cnt == CNT_LAST);
  end

  // Encode from snap: it equals s on the emitting edge and is held stable.
  always_comb begin
    code  = 4'h0;
    n_set = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (snap[i]) begin
        n_set = n_set + 4'd1;
        code  = 4'(i);
      end
    end
    code_err = (n_set > 4'd1);
    if (code_err)
      code = 4'hF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= 4'h0;
      err   <= 1'b0;
      valid <= 1'b0;
      ovf   <= 1'b0;
    end else if (emit && (!valid || ready)) begin
      out   <= code;
      err   <= code_err;
      valid <= 1'b1;
    end else if (emit) begin
      ovf <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_enc.sv
// Testbench for key_enc: directed scenarios plus random key traffic,
// checked every cycle against a behavioural model of press/release debouncing.
`timescale 1ns/1ps

module tb_key_enc;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] keys = '0;
  logic       rdy = 1'b0;
  logic [3:0] out;
  logic       err, valid, ovf;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int last_out = 0;
  int last_err = 0;

  key_enc #(.DEBOUNCE(DEB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (keys),
    .out   (out),
    .err   (err),
    .valid (valid),
    .ready (rdy),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: delay line for synchronization, then press/release tracking.
  logic [9:0] m_d1 = '0, m_d2 = '0, m_snap = '0;
  int   m_phase = 0;  // 0 waiting, 1 confirming press, 2 key down, 3 confirming release
  int   m_age = 0;
  logic m_valid = 0, m_err = 0, m_ovf = 0;
  logic [3:0] m_out = '0;

  function automatic logic [3:0] enc_key(input logic [9:0] k);
    logic [3:0] r;
    r = 4'hF;
    if ($countones(k) == 1)
      for (int i = 0; i < 10; i++)
        if (k == (10'd1 << i)) r = 4'(i);
    return r;
  endfunction

  initial begin
    logic emit_m;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_d1 = '0; m_d2 = '0; m_snap = '0; m_phase = 0; m_age = 0;
        m_valid = 0; m_err = 0; m_ovf = 0; m_out = '0;
      end else begin
        emit_m = 1'b0;
        case (m_phase)
          0: if (m_d2 != 0) begin m_snap = m_d2; m_age = 1; m_phase = 1; end
          1: if (m_d2 != m_snap) m_phase = 0;
             else if (m_age == DEB) begin emit_m = 1'b1; m_phase = 2; end
             else m_age++;
          2: if (m_d2 == 0) begin m_age = 1; m_phase = 3; end
          default: if (m_d2 != 0) m_phase = 2;
                   else if (m_age == DEB) m_phase = 0;
                   else m_age++;
        endcase
        if (emit_m && (!m_valid || rdy)) begin
          m_valid = 1'b1;
          m_out   = enc_key(m_snap);
          m_err   = ($countones(m_snap) > 1);
        end else if (emit_m) begin
          m_ovf = 1'b1;
        end else if (m_valid && rdy) begin
          m_valid = 1'b0;
        end
        m_d2 = m_d1;
        m_d1 = keys;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", int'(valid), int'(m_valid));
      chk("out", int'(out), int'(m_out));
      chk("err", int'(err), int'(m_err));
      chk("ovf", int'(ovf), int'(m_ovf));
      if (valid) begin
        vcount++;
        last_out = int'(out);
        last_err = int'(err);
      end
    end
  end

  task automatic step(input logic [9:0] k, input logic r, input int n);
    keys = k;
    rdy  = r;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    logic [9:0] k;
    int hold, rel;

    repeat (3) begin @(negedge clk); #1; end
    chk("rst_valid", int'(valid), 0);
    chk("rst_out", int'(out), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    step(10'd0, 1'b1, 3);

    // key 7 held 20 cycles, ready high
    vcount = 0;
    step(10'd1 << 7, 1'b1, DEB + 2);
    chk("k7_before", int'(valid), 0);
    step(10'd1 << 7, 1'b1, 1);
    chk("k7_at_edge", int'(valid), 1);
    chk("k7_out", int'(out), 7);
    step(10'd1 << 7, 1'b1, 1);
    chk("k7_consumed", int'(valid), 0);
    step(10'd1 << 7, 1'b1, 20 - DEB - 4);
    step(10'd0, 1'b1, 12);
    chk("k7_count", vcount, 1);
    chk("k7_last_out", last_out, 7);
    chk("k7_last_err", last_err, 0);

    // key 3 short pulse
    vcount = 0;
    step(10'd1 << 3, 1'b1, 2);
    step(10'd0, 1'b1, 12);
    chk("k3_count", vcount, 0);
    chk("k3_ovf", int'(ovf), 0);

    // keys 2+5 together
    vcount = 0;
    step(10'b0000100100, 1'b1, 10);
    step(10'd0, 1'b1, 12);
    chk("k25_count", vcount, 1);
    chk("k25_out", last_out, 15);
    chk("k25_err", last_err, 1);

    // key 9 with release bounce
    vcount = 0;
    step(10'd1 << 9, 1'b1, 10);
    step(10'd0, 1'b1, 2);
    step(10'd1 << 9, 1'b1, 1);
    step(10'd0, 1'b1, 12);
    chk("k9_count", vcount, 1);
    chk("k9_out", last_out, 9);

    // overflow: key 1 then key 4 with ready low
    step(10'd1 << 1, 1'b0, 8);
    chk("ovf_k1_valid", int'(valid), 1);
    chk("ovf_k1_out", int'(out), 1);
    step(10'd0, 1'b0, 12);
    step(10'd1 << 4, 1'b0, 8);
    chk("ovf_k4_valid", int'(valid), 1);
    chk("ovf_k4_out", int'(out), 1);
    chk("ovf_set", int'(ovf), 1);
    step(10'd0, 1'b0, 12);
    step(10'd0, 1'b1, 1);
    chk("ovf_drain", int'(valid), 0);
    vcount = 0;
    step(10'd0, 1'b1, 10);
    chk("ovf_no_k4", vcount, 0);
    chk("ovf_sticky", int'(ovf), 1);

    // key 6, reset while held, re-detected after reset
    step(10'd1 << 6, 1'b0, 8);
    chk("k6_valid", int'(valid), 1);
    chk("k6_out", int'(out), 6);
    rst_n = 1'b0;
    step(10'd1 << 6, 1'b0, 2);
    chk("k6_rst_valid", int'(valid), 0);
    chk("k6_rst_out", int'(out), 0);
    chk("k6_rst_err", int'(err), 0);
    chk("k6_rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    step(10'd1 << 6, 1'b0, DEB + 2);
    chk("k6_re_before", int'(valid), 0);
    step(10'd1 << 6, 1'b0, 1);
    chk("k6_re_valid", int'(valid), 1);
    chk("k6_re_out", int'(out), 6);
    step(10'd0, 1'b1, 12);

    // random traffic against the model
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 4) == 0) k = 10'($urandom_range(1, 1023));
      else k = 10'd1 << $urandom_range(0, 9);
      hold = $urandom_range(1, 12);
      rel  = $urandom_range(1, 12);
      for (int c = 0; c < hold; c++) step(k, 1'($urandom_range(0, 1)), 1);
      for (int c = 0; c < rel; c++) begin
        if ($urandom_range(0, 9) == 0) step(k, 1'($urandom_range(0, 1)), 1);
        else step(10'd0, 1'($urandom_range(0, 1)), 1);
      end
    end
    step(10'd0, 1'b1, 12);
    chk("final_idle", int'(valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_enc.md
KEY_ENC -- requirements
Module: key_enc

Interface
REQ-001 Parameter: DEBOUNCE, 4, number of consecutive stable synchronized samples needed to accept a press or a release (legal range 1..255).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: in  input  10  decimal key lines 0..9, active-high, asynchronous to clk.
REQ-005 Port: out  output  4  encoded key code.
REQ-006 Port: err  output  1  high when the delivered code came from more than one key.
REQ-007 Port: valid  output  1  out/err hold a code not yet consumed.
REQ-008 Port: ready  input  1  consumer accepts the code on a clock edge where valid=1.
REQ-009 Port: ovf  output  1  sticky flag: a code was dropped because the output was still occupied.
REQ-010 The block has one clock; reset is asynchronous and active-low.

Function
REQ-011 in SHALL pass through a 2-flop synchronizer; s denotes the second-stage value, and all logic below uses only s.
REQ-012 Encoding SHALL follow these rules: exactly one bit k set gives out=k, err=0; two or more bits set gives out=4'hF, err=1; s=0 produces no code.
REQ-013 The FSM SHALL have exactly four states: IDLE, DEB, HELD and REL, with an 8-bit counter cnt.
REQ-014 In IDLE, when s!=0, the block SHALL latch snap<=s, clear cnt and go to DEB; when s=0 it SHALL stay in IDLE.
REQ-015 In DEB, when s!=snap (including s=0), the block SHALL go to IDLE with no code emitted.
REQ-016 In DEB, when s==snap, the block SHALL emit a code and go to HELD if cnt==DEBOUNCE-1, and otherwise SHALL increment cnt.
REQ-017 In HELD, any nonzero s, including added or changed keys, SHALL be ignored; when s=0 the block SHALL clear cnt and go to REL.
REQ-018 In REL, when s!=0, the block SHALL return to HELD with no new code (release bounce).
REQ-019 In REL, when s=0, the block SHALL go to IDLE if cnt==DEBOUNCE-1, and otherwise SHALL increment cnt.
REQ-020 Emission latency: with in stable from the first edge that samples it (edge 1), valid SHALL rise after edge DEBOUNCE+3; with the default DEBOUNCE this is edge 7.
REQ-021 An emission SHALL load out/err and set valid=1 when valid=0, or when valid=1 and ready=1 on the same edge (back-to-back; new code replaces the consumed one).
REQ-022 An emission while valid=1 and ready=0 SHALL discard the new code, leave out/err/valid unchanged and set ovf=1.
REQ-023 While valid=1 and no emission is occurring, out and err SHALL remain stable until an edge with ready=1, after which valid SHALL be 0.
REQ-024 ready while valid=0 SHALL have no effect.
REQ-025 ovf SHALL clear only on reset.
REQ-026 Exactly one code SHALL be produced per press/release cycle, regardless of hold length.

Reset
REQ-027 On rst_n=0, the block SHALL immediately and asynchronously force: synchronizer flops=0, state=IDLE, cnt=0, snap=0, out=4'h0, err=0, valid=0, ovf=0.
REQ-028 Reset asserted mid-debounce or mid-handshake SHALL abort the operation and drop any pending code.
REQ-029 After rst_n deasserts, a key still held SHALL be detected as a new press per REQ-020.

Verification
REQ-030 Key 7 held 20 cycles with ready=1 -> valid=1 for exactly one cycle after edge 7 with out=7, err=0; no further code.
REQ-031 Key 3 pulsed for 2 cycles, then released -> valid never asserts and ovf=0.
REQ-032 Keys 2 and 5 pressed together and held 10 cycles -> one code: out=4'hF, err=1.
REQ-033 ready=0; press/release key 1, then press/release key 4 -> valid=1 and out=1 throughout, ovf=1 after key 4's emission edge; ready=1 for one cycle -> valid=0; key 4 never appears.
REQ-034 Key 9 held; during release, in bounces high for 1 cycle then stays low -> exactly one code, out=9.
REQ-035 Key 6 emitted with ready=0, then rst_n pulsed low while key 6 is still held -> valid/out/err/ovf read 0 during reset; after release a fresh code out=6 appears DEBOUNCE+3 edges later.
